// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait, mul/div
// occupancy, taken branches and load-use into stage enables. Optional perf counters: PIPELINE_CTRL_PERF_EN.
//
// state   | meaning
// RUN     | normal issue; branch and load-use hazards are evaluated
// MD_WAIT | mul/div occupies EX; front end frozen until md_cnt reaches 0
module pipeline_ctrl #(
    parameter int MD_LATENCY = 32
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    parameter int PERF_W     = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dmem_wait,
    input  logic       ex_md_start,
    input  logic       ex_br_taken,
    input  logic       de_memRead,
    input  logic [4:0] de_rd,
    input  logic [4:0] fd_rs1,
    input  logic [4:0] fd_rs2,
    output logic       pcWrite,
    output logic       fdWrite,
    output logic       deWrite,
    output logic       emWrite,
    output logic       mwWrite,
    output logic       fdFlush,
    output logic       deFlush,
    output logic       emBubble,
    output logic       md_busy,
    output logic       md_done
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_lu_stalls,
    output logic [PERF_W-1:0] perf_br_flushes,
    output logic [PERF_W-1:0] perf_md_cycles,
    output logic [PERF_W-1:0] perf_mem_stalls
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // The issue cycle and the md_done cycle are both part of the occupancy.
    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 2);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] md_cnt;
    logic [7:0] md_cnt_nxt;
    logic       load_use;
    logic       hit_mem;
    logic       hit_md;
    logic       hit_br;
    logic       hit_lu;

    assign load_use = de_memRead && (de_rd != 5'd0) &&
                      ((de_rd == fd_rs1) || (de_rd == fd_rs2));

    assign md_busy = (state == MD_WAIT);

    always_comb begin
        pcWrite    = 1'b1;
        fdWrite    = 1'b1;
        deWrite    = 1'b1;
        emWrite    = 1'b1;
        mwWrite    = 1'b1;
        fdFlush    = 1'b0;
        deFlush    = 1'b0;
        emBubble   = 1'b0;
        md_done    = 1'b0;
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        hit_mem    = 1'b0;
        hit_md     = 1'b0;
        hit_br     = 1'b0;
        hit_lu     = 1'b0;

        if (dmem_wait) begin
            // Whole pipe holds; the mul/div timer keeps running but cannot finish.
            hit_mem = 1'b1;
            pcWrite = 1'b0;
            fdWrite = 1'b0;
            deWrite = 1'b0;
            emWrite = 1'b0;
            mwWrite = 1'b0;
            if (md_cnt != 8'd0) begin
                md_cnt_nxt = md_cnt - 8'd1;
            end
        end else if (state == RUN && ex_md_start) begin
            hit_md     = 1'b1;
            pcWrite    = 1'b0;
            fdWrite    = 1'b0;
            deWrite    = 1'b0;
            emBubble   = 1'b1;
            state_nxt  = MD_WAIT;
            md_cnt_nxt = MD_LOAD;
        end else if (state == MD_WAIT && md_cnt != 8'd0) begin
            hit_md     = 1'b1;
            pcWrite    = 1'b0;
            fdWrite    = 1'b0;
            deWrite    = 1'b0;
            emBubble   = 1'b1;
            md_cnt_nxt = md_cnt - 8'd1;
        end else if (state == MD_WAIT) begin
            hit_md    = 1'b1;
            md_done   = 1'b1;
            state_nxt = RUN;
        end else if (ex_br_taken) begin
            // ID holds a wrong-path instruction, so its load-use match is moot.
            hit_br  = 1'b1;
            fdFlush = 1'b1;
            deFlush = 1'b1;
        end else if (load_use) begin
            hit_lu  = 1'b1;
            pcWrite = 1'b0;
            fdWrite = 1'b0;
            deFlush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lu_stalls  <= '0;
            perf_br_flushes <= '0;
            perf_md_cycles  <= '0;
            perf_mem_stalls <= '0;
        end else begin
            if (hit_lu)  perf_lu_stalls  <= perf_lu_stalls + 1'b1;
            if (hit_br)  perf_br_flushes <= perf_br_flushes + 1'b1;
            if (hit_md)  perf_md_cycles  <= perf_md_cycles + 1'b1;
            if (hit_mem) perf_mem_stalls <= perf_mem_stalls + 1'b1;
        end
    end
`else
    logic unused_hits;
    assign unused_hits = ^{hit_mem, hit_md, hit_br, hit_lu};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios followed by random traffic,
// every cycle compared against an occupancy-based reference model.
module tb_pipeline_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       dmem_wait, ex_md_start, ex_br_taken, de_memRead;
    logic [4:0] de_rd, fd_rs1, fd_rs2;
    logic       pcWrite, fdWrite, deWrite, emWrite, mwWrite;
    logic       fdFlush, deFlush, emBubble, md_busy, md_done;
`ifdef PIPELINE_CTRL_PERF_EN
    localparam int PW = 4;
    logic [PW-1:0] perf_lu_stalls, perf_br_flushes, perf_md_cycles, perf_mem_stalls;
    int p_lu, p_br, p_md, p_mem;
`endif

    pipeline_ctrl #(
        .MD_LATENCY(LAT)
`ifdef PIPELINE_CTRL_PERF_EN
        , .PERF_W(PW)
`endif
    ) dut (
        .clk(clk), .reset(reset), .dmem_wait(dmem_wait), .ex_md_start(ex_md_start),
        .ex_br_taken(ex_br_taken), .de_memRead(de_memRead), .de_rd(de_rd),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .pcWrite(pcWrite), .fdWrite(fdWrite),
        .deWrite(deWrite), .emWrite(emWrite), .mwWrite(mwWrite), .fdFlush(fdFlush),
        .deFlush(deFlush), .emBubble(emBubble), .md_busy(md_busy), .md_done(md_done)
`ifdef PIPELINE_CTRL_PERF_EN
        , .perf_lu_stalls(perf_lu_stalls), .perf_br_flushes(perf_br_flushes)
        , .perf_md_cycles(perf_md_cycles), .perf_mem_stalls(perf_mem_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: is a mul/div occupying EX, and how many more wait cycles before it may finish.
    bit         m_busy;
    int         m_left;
    logic [9:0] last_out;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        dmem_wait = 0; ex_md_start = 0; ex_br_taken = 0;
        de_memRead = 0; de_rd = 0; fd_rs1 = 0; fd_rs2 = 0;
    endtask

    // Output vector order: pc fd de em mw fdFlush deFlush emBubble md_busy md_done
    task automatic step(input string tag);
        logic [9:0] exp;
        bit lu;
        bit nb;
        int nl;
        bit c_lu, c_br, c_md, c_mem;
        @(negedge clk);
        lu = de_memRead && de_rd != 0 && (de_rd == fd_rs1 || de_rd == fd_rs2);
        nb = m_busy; nl = m_left;
        c_lu = 0; c_br = 0; c_md = 0; c_mem = 0;
        if (dmem_wait) begin
            exp = {5'b00000, 3'b000, m_busy, 1'b0};
            nl = (m_left > 0) ? m_left - 1 : 0;
            c_mem = 1;
        end else if (!m_busy && ex_md_start) begin
            exp = {5'b00011, 3'b001, 1'b0, 1'b0};
            nb = 1; nl = LAT - 2; c_md = 1;
        end else if (m_busy && m_left > 0) begin
            exp = {5'b00011, 3'b001, 1'b1, 1'b0};
            nl = m_left - 1; c_md = 1;
        end else if (m_busy) begin
            exp = {5'b11111, 3'b000, 1'b1, 1'b1};
            nb = 0; c_md = 1;
        end else if (ex_br_taken) begin
            exp = {5'b11111, 3'b110, 2'b00};
            c_br = 1;
        end else if (lu) begin
            exp = {5'b00111, 3'b010, 2'b00};
            c_lu = 1;
        end else begin
            exp = {5'b11111, 3'b000, 2'b00};
        end
        last_out = {pcWrite, fdWrite, deWrite, emWrite, mwWrite,
                    fdFlush, deFlush, emBubble, md_busy, md_done};
        check_val(tag, 32'(last_out), 32'(exp));
`ifdef PIPELINE_CTRL_PERF_EN
        check_val({tag, "_perf"},
                  32'({perf_lu_stalls, perf_br_flushes, perf_md_cycles, perf_mem_stalls}),
                  32'({4'(p_lu), 4'(p_br), 4'(p_md), 4'(p_mem)}));
`endif
        @(posedge clk);
        #1;
        if (reset) begin
            m_busy = 0; m_left = 0;
`ifdef PIPELINE_CTRL_PERF_EN
            p_lu = 0; p_br = 0; p_md = 0; p_mem = 0;
`endif
        end else begin
            m_busy = nb; m_left = nl;
`ifdef PIPELINE_CTRL_PERF_EN
            p_lu = (p_lu + int'(c_lu)) % (1 << PW);
            p_br = (p_br + int'(c_br)) % (1 << PW);
            p_md = (p_md + int'(c_md)) % (1 << PW);
            p_mem = (p_mem + int'(c_mem)) % (1 << PW);
`endif
        end
    endtask

    task automatic do_reset();
        reset = 1; idle();
        step("reset");
        check_val("reset_idle", 32'(last_out), 32'(10'b1111100000));
        reset = 0;
    endtask

    initial begin
        reset = 1; idle();
        m_busy = 0; m_left = 0; last_out = '0;
`ifdef PIPELINE_CTRL_PERF_EN
        p_lu = 0; p_br = 0; p_md = 0; p_mem = 0;
`endif
        @(posedge clk); #1;
        do_reset();

        // Load-use stall, then bubble clears it; x0 never stalls.
        de_memRead = 1; de_rd = 5; fd_rs1 = 5;
        step("lu_stall");
        check_val("lu_pattern", 32'(last_out), 32'(10'b0011101000));
        de_memRead = 0;
        step("lu_after");
        check_val("lu_one_cycle", 32'(last_out), 32'(10'b1111100000));
        de_memRead = 1; de_rd = 0; fd_rs1 = 0;
        step("lu_x0");
        check_val("lu_x0_nostall", 32'(last_out), 32'(10'b1111100000));

        // Branch beats load-use.
        de_rd = 5; fd_rs1 = 5; ex_br_taken = 1;
        step("br_lu");
        check_val("br_over_lu", 32'(last_out), 32'(10'b1111111000));
        idle();

        // Plain mul/div occupancy.
        ex_md_start = 1;
        step("md_c0");
        check_val("md_issue", 32'(last_out), 32'(10'b0001100100));
        ex_md_start = 0;
        step("md_c1");
        step("md_c2");
        check_val("md_freeze", 32'(last_out), 32'(10'b0001100110));
        step("md_c3");
        check_val("md_done_cyc", 32'(last_out), 32'(10'b1111100011));
        step("md_c4");
        check_val("md_back_run", 32'(last_out), 32'(10'b1111100000));

        // Memory wait coinciding with md_cnt==0 stretches the op.
        ex_md_start = 1;
        step("mw_c0");
        ex_md_start = 0;
        step("mw_c1");
        step("mw_c2");
        dmem_wait = 1;
        step("mw_c3");
        check_val("mw_hold3", 32'(last_out), 32'(10'b0000000010));
        step("mw_c4");
        check_val("mw_hold4", 32'(last_out), 32'(10'b0000000010));
        dmem_wait = 0;
        step("mw_c5");
        check_val("mw_done5", 32'(last_out), 32'(10'b1111100011));
        step("mw_c6");

        // Reset in the middle of a mul/div abandons it.
        ex_md_start = 1;
        step("rm_c0");
        ex_md_start = 0; reset = 1;
        step("rm_c1");
        reset = 0;
        step("rm_c2");
        check_val("rm_idle", 32'(last_out), 32'(10'b1111100000));
        de_memRead = 1; de_rd = 7; fd_rs2 = 7;
        step("rm_lu");
        check_val("rm_lu_stall", 32'(last_out), 32'(10'b0011101000));
        idle();
        step("rm_tail");

`ifdef PIPELINE_CTRL_PERF_EN
        do_reset();
        de_memRead = 1; de_rd = 3; fd_rs1 = 3;
        step("pf_lu1");
        idle(); step("pf_i1");
        de_memRead = 1; de_rd = 4; fd_rs2 = 4;
        step("pf_lu2");
        idle(); ex_br_taken = 1;
        step("pf_br");
        idle(); ex_md_start = 1;
        step("pf_md0");
        ex_md_start = 0;
        for (int i = 0; i < 3; i++) step("pf_md");
        dmem_wait = 1;
        for (int i = 0; i < 3; i++) step("pf_mem");
        dmem_wait = 0;
        step("pf_idle");
        check_val("pf_lu_cnt", 32'(perf_lu_stalls), 32'd2);
        check_val("pf_br_cnt", 32'(perf_br_flushes), 32'd1);
        check_val("pf_md_cnt", 32'(perf_md_cycles), 32'd4);
        check_val("pf_mem_cnt", 32'(perf_mem_stalls), 32'd3);
        dmem_wait = 1;
        for (int i = 0; i < 13; i++) step("pf_wrap");
        dmem_wait = 0;
        step("pf_wrap_idle");
        check_val("pf_mem_wrap", 32'(perf_mem_stalls), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            reset = ($urandom_range(0, 99) < 2);
            dmem_wait = ($urandom_range(0, 99) < 20);
            r = int'($urandom_range(0, 99));
            ex_md_start = (r < 10);
            ex_br_taken = (r >= 10 && r < 25);
            de_memRead = $urandom_range(0, 1);
            de_rd = 5'($urandom_range(0, 3));
            fd_rs1 = 5'($urandom_range(0, 3));
            fd_rs2 = 5'($urandom_range(0, 3));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
